// File: rtl/vesa_timing_gen_cfg.sv
// Runtime-programmable VESA timing generator: hsync/vsync/de/counters with frame-boundary config updates.
// Optional test pattern output pix_rgb is built when VESA_TIMING_PATTERN_EN is defined.
module vesa_timing_gen_cfg #(
    parameter int CNT_W      = 16,
    parameter int DEF_H_ACT  = 3840,
    parameter int DEF_H_FP   = 48,
    parameter int DEF_H_SYNC = 32,
    parameter int DEF_H_BP   = 208,
    parameter int DEF_V_ACT  = 2160,
    parameter int DEF_V_FP   = 3,
    parameter int DEF_V_SYNC = 5,
    parameter int DEF_V_BP   = 31,
    parameter bit DEF_HS_POL = 1'b1,
    parameter bit DEF_VS_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [4*CNT_W-1:0] cfg_h,
    input  logic [4*CNT_W-1:0] cfg_v,
    input  logic [1:0]         cfg_pol,
    output logic               cfg_err,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_start,
    output logic [CNT_W-1:0]   h_count,
    output logic [CNT_W-1:0]   v_count
`ifdef VESA_TIMING_PATTERN_EN
    ,
    output logic [23:0]        pix_rgb
`endif
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [4*CNT_W-1:0] DEF_H = {CNT_W'(DEF_H_ACT), CNT_W'(DEF_H_FP),
                                            CNT_W'(DEF_H_SYNC), CNT_W'(DEF_H_BP)};
    localparam logic [4*CNT_W-1:0] DEF_V = {CNT_W'(DEF_V_ACT), CNT_W'(DEF_V_FP),
                                            CNT_W'(DEF_V_SYNC), CNT_W'(DEF_V_BP)};
    localparam logic [1:0]         DEF_POL  = {DEF_HS_POL, DEF_VS_POL};
    localparam logic [CNT_W+1:0]   TOT_ONE  = {{(CNT_W+1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] fld_act(input logic [4*CNT_W-1:0] t);
        fld_act = t[4*CNT_W-1 -: CNT_W];
    endfunction

    function automatic logic [CNT_W+1:0] fld_total(input logic [4*CNT_W-1:0] t);
        fld_total = {2'b00, t[4*CNT_W-1 -: CNT_W]} + {2'b00, t[3*CNT_W-1 -: CNT_W]}
                  + {2'b00, t[2*CNT_W-1 -: CNT_W]} + {2'b00, t[CNT_W-1:0]};
    endfunction

    // A timing set is usable only with non-zero active and sync widths and a total that fits the counters.
    function automatic logic fld_ok(input logic [4*CNT_W-1:0] t);
        logic [CNT_W+1:0] tot;
        tot    = fld_total(t);
        fld_ok = (t[4*CNT_W-1 -: CNT_W] != '0) && (t[2*CNT_W-1 -: CNT_W] != '0)
              && (tot[CNT_W+1:CNT_W] == 2'b00);
    endfunction

    function automatic logic in_sync(input logic [CNT_W-1:0] pos, input logic [4*CNT_W-1:0] t);
        logic [CNT_W+1:0] s0;
        s0      = {2'b00, t[4*CNT_W-1 -: CNT_W]} + {2'b00, t[3*CNT_W-1 -: CNT_W]};
        in_sync = ({2'b00, pos} >= s0) && ({2'b00, pos} < s0 + {2'b00, t[2*CNT_W-1 -: CNT_W]});
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   h_count_q, h_count_d, v_count_q, v_count_d;
    logic               de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic               frame_start_q, frame_start_d, cfg_err_q, cfg_err_d;
    logic               cfg_ready_q, cfg_ready_d, pend_valid_q, pend_valid_d;
    logic [4*CNT_W-1:0] live_h_q, live_h_d, live_v_q, live_v_d;
    logic [4*CNT_W-1:0] pend_h_q, pend_h_d, pend_v_q, pend_v_d;
    logic [1:0]         live_pol_q, live_pol_d, pend_pol_q, pend_pol_d;
    logic [4*CNT_W-1:0] use_h_s, use_v_s;
    logic [1:0]         use_pol_s;
    logic               h_last_s, v_last_s, apply_s, accept_s, cfg_ok_s;

    // Next-pixel computation; outputs are derived from the next counters so they stay aligned.
    always_comb begin
        h_last_s  = ({2'b00, h_count_q} == fld_total(live_h_q) - TOT_ONE);
        v_last_s  = ({2'b00, v_count_q} == fld_total(live_v_q) - TOT_ONE);
        apply_s   = pend_valid_q && ((state_q == ST_IDLE) || (h_last_s && v_last_s));
        use_h_s   = apply_s ? pend_h_q   : live_h_q;
        use_v_s   = apply_s ? pend_v_q   : live_v_q;
        use_pol_s = apply_s ? pend_pol_q : live_pol_q;
        accept_s  = cfg_valid && cfg_ready_q;
        cfg_ok_s  = fld_ok(cfg_h) && fld_ok(cfg_v);
        state_d   = en ? ST_RUN : ST_IDLE;

        if (en && (state_q == ST_RUN)) begin
            if (h_last_s) begin
                h_count_d = '0;
                v_count_d = v_last_s ? '0 : v_count_q + CNT_ONE;
            end else begin
                h_count_d = h_count_q + CNT_ONE;
                v_count_d = v_count_q;
            end
        end else begin
            h_count_d = '0;
            v_count_d = '0;
        end

        de_d          = en && (h_count_d < fld_act(use_h_s)) && (v_count_d < fld_act(use_v_s));
        hsync_d       = (en && in_sync(h_count_d, use_h_s)) ? use_pol_s[1] : ~use_pol_s[1];
        vsync_d       = (en && in_sync(v_count_d, use_v_s)) ? use_pol_s[0] : ~use_pol_s[0];
        frame_start_d = en && (h_count_d == '0) && (v_count_d == '0);

        cfg_err_d     = accept_s && !cfg_ok_s;
        pend_h_d      = (accept_s && cfg_ok_s) ? cfg_h   : pend_h_q;
        pend_v_d      = (accept_s && cfg_ok_s) ? cfg_v   : pend_v_q;
        pend_pol_d    = (accept_s && cfg_ok_s) ? cfg_pol : pend_pol_q;
        pend_valid_d  = (pend_valid_q && !apply_s) || (accept_s && cfg_ok_s);
        cfg_ready_d   = !pend_valid_d;
        live_h_d      = use_h_s;
        live_v_d      = use_v_s;
        live_pol_d    = use_pol_s;
    end

    // State, counters, timing registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            h_count_q     <= '0;
            v_count_q     <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~DEF_HS_POL;
            vsync_q       <= ~DEF_VS_POL;
            frame_start_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            cfg_ready_q   <= 1'b1;
            pend_valid_q  <= 1'b0;
            live_h_q      <= DEF_H;
            live_v_q      <= DEF_V;
            live_pol_q    <= DEF_POL;
            pend_h_q      <= DEF_H;
            pend_v_q      <= DEF_V;
            pend_pol_q    <= DEF_POL;
        end else begin
            state_q       <= state_d;
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            cfg_err_q     <= cfg_err_d;
            cfg_ready_q   <= cfg_ready_d;
            pend_valid_q  <= pend_valid_d;
            live_h_q      <= live_h_d;
            live_v_q      <= live_v_d;
            live_pol_q    <= live_pol_d;
            pend_h_q      <= pend_h_d;
            pend_v_q      <= pend_v_d;
            pend_pol_q    <= pend_pol_d;
        end
    end

    assign h_count     = h_count_q;
    assign v_count     = v_count_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign cfg_err     = cfg_err_q;
    assign cfg_ready   = cfg_ready_q;

`ifdef VESA_TIMING_PATTERN_EN
    function automatic logic [23:0] bar_colour(input logic [3:0] idx);
        case (idx)
            4'd0:    bar_colour = 24'hFFFFFF;
            4'd1:    bar_colour = 24'hFFFF00;
            4'd2:    bar_colour = 24'h00FFFF;
            4'd3:    bar_colour = 24'h00FF00;
            4'd4:    bar_colour = 24'hFF00FF;
            4'd5:    bar_colour = 24'hFF0000;
            4'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    endfunction

    logic [CNT_W+2:0] bar_w_s, bar_edge_s;
    logic [3:0]       bar_idx_s;
    logic [23:0]      pix_rgb_q, pix_rgb_d;

    // Bar index = number of bar edges already passed; index 8 and above falls through to black.
    always_comb begin
        bar_w_s    = {3'b000, fld_act(use_h_s) >> 3};
        bar_edge_s = '0;
        bar_idx_s  = 4'd0;
        for (int k = 0; k < 8; k++) begin
            bar_edge_s = bar_edge_s + bar_w_s;
            if ({3'b000, h_count_d} >= bar_edge_s) begin
                bar_idx_s = bar_idx_s + 4'd1;
            end else begin
                bar_idx_s = bar_idx_s;
            end
        end
        pix_rgb_d = de_d ? bar_colour(bar_idx_s) : 24'h000000;
    end

    // Pattern register, aligned with de.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_rgb_q <= 24'h000000;
        end else begin
            pix_rgb_q <= pix_rgb_d;
        end
    end

    assign pix_rgb = pix_rgb_q;
`endif

endmodule

// File: tb/tb_vesa_timing_gen_cfg.sv
// Directed self-checking bench for vesa_timing_gen_cfg; pattern test only when VESA_TIMING_PATTERN_EN is defined.
module tb_vesa_timing_gen_cfg;

    logic        clk = 1'b0;
    logic        rst, en, cfg_valid, cfg_ready, cfg_err;
    logic [63:0] cfg_h, cfg_v;
    logic [1:0]  cfg_pol;
    logic        hsync, vsync, de, frame_start;
    logic [15:0] h_count, v_count;
`ifdef VESA_TIMING_PATTERN_EN
    logic [23:0] pix_rgb;
`endif
    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] TEST_H = {16'd8, 16'd2, 16'd2, 16'd4};
    localparam logic [63:0] TEST_V = {16'd4, 16'd1, 16'd1, 16'd2};
    localparam logic [63:0] NEW_H  = {16'd4, 16'd1, 16'd1, 16'd1};

    vesa_timing_gen_cfg dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_pol(cfg_pol), .cfg_err(cfg_err),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start),
        .h_count(h_count), .v_count(v_count)
`ifdef VESA_TIMING_PATTERN_EN
        , .pix_rgb(pix_rgb)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_h = '0; cfg_v = '0; cfg_pol = 2'b10;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (h_count !== 16'd0) begin failures++; $display("FAIL reset_h got=%0d exp=0", h_count); end
        checks++; if (v_count !== 16'd0) begin failures++; $display("FAIL reset_v got=%0d exp=0", v_count); end
        checks++; if (de !== 1'b0) begin failures++; $display("FAIL reset_de got=%b exp=0", de); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
        checks++; if (hsync !== 1'b0) begin failures++; $display("FAIL reset_hsync got=%b exp=0", hsync); end
        checks++; if (vsync !== 1'b1) begin failures++; $display("FAIL reset_vsync got=%b exp=1", vsync); end
    endtask

    task automatic test_default_line();
        int de_n = 0, hs_n = 0, hs_first = -1, vs_bad = 0;
        en = 1'b1;
        tick();
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL def_fs got=%b exp=1", frame_start); end
        checks++; if (de !== 1'b1) begin failures++; $display("FAIL def_de0 got=%b exp=1", de); end
        for (int i = 0; i < 4128; i++) begin
            if (de === 1'b1) de_n++;
            if (hsync === 1'b1) begin
                hs_n++;
                if (hs_first < 0) hs_first = int'(h_count);
            end
            if (vsync !== 1'b1) vs_bad++;
            tick();
        end
        checks++; if (de_n != 3840) begin failures++; $display("FAIL def_de_len got=%0d exp=3840", de_n); end
        checks++; if (hs_n != 32) begin failures++; $display("FAIL def_hs_len got=%0d exp=32", hs_n); end
        checks++; if (hs_first != 3888) begin failures++; $display("FAIL def_hs_pos got=%0d exp=3888", hs_first); end
        checks++; if (vs_bad != 0) begin failures++; $display("FAIL def_vs_line0 got=%0d exp=0", vs_bad); end
        checks++; if (h_count !== 16'd0 || v_count !== 16'd1) begin
            failures++; $display("FAIL def_wrap got=%0d,%0d exp=0,1", h_count, v_count); end
        en = 1'b0;
        tick();
        checks++; if (de !== 1'b0 || h_count !== 16'd0) begin
            failures++; $display("FAIL def_idle got=de%b h%0d exp=de0 h0", de, h_count); end
    endtask

    task automatic test_load_idle();
        int fs_n = 0, fs_bad = 0, de_n = 0, hs_n = 0, hs_first = -1, vs_n = 0, vs_line = -1, max_h = 0;
        cfg_h = TEST_H; cfg_v = TEST_V; cfg_pol = 2'b10; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL idle_pending got=%b exp=0", cfg_ready); end
        tick();
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL idle_applied got=%b exp=1", cfg_ready); end
        en = 1'b1;
        for (int i = 0; i < 260; i++) begin
            tick();
            if (frame_start === 1'b1) begin
                fs_n++;
                if (i != 0 && i != 128 && i != 256) fs_bad++;
            end
            if (i < 128) begin
                if (de === 1'b1) de_n++;
                if (hsync === 1'b1) begin
                    hs_n++;
                    if (hs_first < 0) hs_first = int'(h_count);
                end
                if (vsync === 1'b0) begin
                    vs_n++;
                    if (vs_line < 0) vs_line = int'(v_count);
                end
                if (int'(h_count) > max_h) max_h = int'(h_count);
            end
        end
        checks++; if (fs_n != 3 || fs_bad != 0) begin failures++; $display("FAIL idle_fs_period got=%0d/%0d exp=3/0", fs_n, fs_bad); end
        checks++; if (de_n != 32) begin failures++; $display("FAIL idle_de_cnt got=%0d exp=32", de_n); end
        checks++; if (hs_n != 16 || hs_first != 10) begin failures++; $display("FAIL idle_hsync got=%0d@%0d exp=16@10", hs_n, hs_first); end
        checks++; if (vs_n != 16 || vs_line != 5) begin failures++; $display("FAIL idle_vsync got=%0d@%0d exp=16@5", vs_n, vs_line); end
        checks++; if (max_h != 15) begin failures++; $display("FAIL idle_htotal got=%0d exp=15", max_h); end
        en = 1'b0;
        tick();
    endtask

    task automatic test_midframe();
        int  eh = 0, ev = 0, ht = 16, hact = 8, hfp = 2, hsy = 2;
        bit  pend = 1'b0, offer, ready_before;
        logic e_de, e_hs, e_vs, e_fs;
        cfg_h = NEW_H;
        en = 1'b1;
        tick();
        for (int i = 1; i <= 200; i++) begin
            offer = (i == 36);
            cfg_valid = offer;
            tick();
            ready_before = !pend;
            if (eh == ht - 1) begin
                eh = 0;
                if (ev == 7) begin
                    ev = 0;
                    if (pend) begin ht = 7; hact = 4; hfp = 1; hsy = 1; pend = 1'b0; end
                end else ev++;
            end else eh++;
            if (offer && ready_before) pend = 1'b1;
            e_de = (eh < hact) && (ev < 4);
            e_hs = (eh >= hact + hfp) && (eh < hact + hfp + hsy);
            e_vs = !(ev == 5);
            e_fs = (eh == 0) && (ev == 0);
            checks++; if (h_count !== 16'(eh) || v_count !== 16'(ev)) begin
                failures++; $display("FAIL mid_cnt cyc=%0d got=%0d,%0d exp=%0d,%0d", i, h_count, v_count, eh, ev); end
            checks++; if (de !== e_de || hsync !== e_hs || vsync !== e_vs || frame_start !== e_fs) begin
                failures++; $display("FAIL mid_out cyc=%0d got=%b%b%b%b exp=%b%b%b%b", i, de, hsync, vsync, frame_start, e_de, e_hs, e_vs, e_fs); end
            checks++; if (cfg_ready !== !pend) begin
                failures++; $display("FAIL mid_ready cyc=%0d got=%b exp=%b", i, cfg_ready, !pend); end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reject();
        logic [63:0] bad [3];
        bad[0] = {16'd0, 16'd2, 16'd2, 16'd4};
        bad[1] = {16'd8, 16'd2, 16'd0, 16'd4};
        bad[2] = {16'hFFFF, 16'd1, 16'd1, 16'd1};
        cfg_v = TEST_V;
        for (int k = 0; k < 3; k++) begin
            cfg_h = bad[k]; cfg_valid = 1'b1;
            tick();
            cfg_valid = 1'b0;
            checks++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
                failures++; $display("FAIL rej%0d_pulse got=err%b rdy%b exp=err1 rdy1", k, cfg_err, cfg_ready); end
            tick();
            checks++; if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
                failures++; $display("FAIL rej%0d_after got=err%b rdy%b exp=err0 rdy1", k, cfg_err, cfg_ready); end
        end
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL rej_fs got=%b exp=1", frame_start); end
        repeat (6) tick();
        checks++; if (h_count !== 16'd6) begin failures++; $display("FAIL rej_hmax got=%0d exp=6", h_count); end
        tick();
        checks++; if (h_count !== 16'd0 || v_count !== 16'd1) begin
            failures++; $display("FAIL rej_wrap got=%0d,%0d exp=0,1", h_count, v_count); end
    endtask

    task automatic test_en_abort();
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (h_count === 16'd5 && v_count === 16'd2) found = 1'b1;
            else tick();
        end
        checks++; if (!found) begin failures++; $display("FAIL abort_wait got=timeout exp=h5v2"); end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (de !== 1'b0 || h_count !== 16'd0 || v_count !== 16'd0 || frame_start !== 1'b0
                          || hsync !== 1'b0 || vsync !== 1'b1) begin
                failures++; $display("FAIL abort_idle%0d got=de%b h%0d v%0d fs%b hs%b vs%b exp=de0 h0 v0 fs0 hs0 vs1",
                                     k, de, h_count, v_count, frame_start, hsync, vsync); end
        end
        en = 1'b1;
        tick();
        checks++; if (frame_start !== 1'b1 || de !== 1'b1 || h_count !== 16'd0 || v_count !== 16'd0) begin
            failures++; $display("FAIL abort_resume got=fs%b de%b h%0d v%0d exp=fs1 de1 h0 v0", frame_start, de, h_count, v_count); end
        tick();
        checks++; if (frame_start !== 1'b0 || h_count !== 16'd1) begin
            failures++; $display("FAIL abort_next got=fs%b h%0d exp=fs0 h1", frame_start, h_count); end
    endtask

`ifdef VESA_TIMING_PATTERN_EN
    task automatic test_pattern();
        logic [23:0] tab [8];
        logic [23:0] exp_rgb;
        tab[0] = 24'hFFFFFF; tab[1] = 24'hFFFF00; tab[2] = 24'h00FFFF; tab[3] = 24'h00FF00;
        tab[4] = 24'hFF00FF; tab[5] = 24'hFF0000; tab[6] = 24'h0000FF; tab[7] = 24'h000000;
        en = 1'b0;
        tick();
        cfg_h = TEST_H; cfg_v = TEST_V; cfg_pol = 2'b10; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        en = 1'b1;
        for (int x = 0; x < 16; x++) begin
            tick();
            exp_rgb = (x < 8) ? tab[x] : 24'h000000;
            checks++; if (pix_rgb !== exp_rgb) begin
                failures++; $display("FAIL pattern_h%0d got=%h exp=%h", x, pix_rgb, exp_rgb); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_default_line();
        test_load_idle();
        test_midframe();
        test_reject();
        test_en_abort();
`ifdef VESA_TIMING_PATTERN_EN
        test_pattern();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
